// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use / RAW hazard stall with bubble insertion, and EX-stage forwarding selects.
module pipe_ctrl_unit #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int FWD_EN  = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [6:0]          opcode_i,
    input  logic [REG_AW-1:0]   rs1_i,
    input  logic [REG_AW-1:0]   rs2_i,
    input  logic [REG_AW-1:0]   rd_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic [ALUOP_W-1:0]  ex_aluop_o,
    output logic                ex_alusrc_o,
    output logic                ex_branch_o,
    output logic                mem_memread_o,
    output logic                mem_memwrite_o,
    output logic                wb_regwrite_o,
    output logic                wb_memtoreg_o,
    output logic [REG_AW-1:0]   wb_rd_o,
    output logic [1:0]          fwd_a_o,
    output logic [1:0]          fwd_b_o
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic               w_regwrite, w_memtoreg, w_memread, w_memwrite, w_branch, w_alusrc;
    logic [ALUOP_W-1:0] w_aluop;
    logic               w_use_rs1, w_use_rs2;
    logic               w_ex_hit, w_mem_hit, w_hazard, w_bubble;
    logic [1:0]         w_fwd_a, w_fwd_b;

    logic               r_ex_regwrite, r_ex_memtoreg, r_ex_memread, r_ex_memwrite;
    logic               r_ex_branch, r_ex_alusrc;
    logic [ALUOP_W-1:0] r_ex_aluop;
    logic [REG_AW-1:0]  r_ex_rs1, r_ex_rs2, r_ex_rd;
    logic               r_mem_regwrite, r_mem_memtoreg, r_mem_memread, r_mem_memwrite;
    logic [REG_AW-1:0]  r_mem_rd;
    logic               r_wb_regwrite, r_wb_memtoreg;
    logic [REG_AW-1:0]  r_wb_rd;

    always_comb begin
        w_regwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_branch   = 1'b0;
        w_alusrc   = 1'b0;
        w_aluop    = '0;
        w_use_rs1  = 1'b0;
        w_use_rs2  = 1'b0;
        case (opcode_i)
            OP_R: begin
                w_regwrite   = 1'b1;
                w_aluop[1:0] = 2'b10;
                w_use_rs1    = 1'b1;
                w_use_rs2    = 1'b1;
            end
            OP_I: begin
                w_regwrite   = 1'b1;
                w_alusrc     = 1'b1;
                w_aluop[1:0] = 2'b11;
                w_use_rs1    = 1'b1;
            end
            OP_LD: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_memread  = 1'b1;
                w_alusrc   = 1'b1;
                w_use_rs1  = 1'b1;
            end
            OP_ST: begin
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
            end
            OP_BR: begin
                w_branch     = 1'b1;
                w_aluop[1:0] = 2'b01;
                w_use_rs1    = 1'b1;
                w_use_rs2    = 1'b1;
            end
            default: ;
        endcase
    end

    // Unused rs fields are masked so stray encoding bits never raise a hazard.
    assign w_ex_hit  = (r_ex_rd != '0) &&
                       ((w_use_rs1 && rs1_i == r_ex_rd) || (w_use_rs2 && rs2_i == r_ex_rd));
    assign w_mem_hit = (r_mem_rd != '0) &&
                       ((w_use_rs1 && rs1_i == r_mem_rd) || (w_use_rs2 && rs2_i == r_mem_rd));

    assign w_hazard = (FWD_EN != 0) ? (r_ex_memread & w_ex_hit)
                                    : ((r_ex_regwrite & w_ex_hit) | (r_mem_regwrite & w_mem_hit));
    assign w_bubble = w_hazard | flush_i;
    assign stall_o  = w_hazard & ~flush_i;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (r_mem_regwrite && r_mem_rd != '0 && r_mem_rd == rs)
            return 2'b10;
        else if (r_wb_regwrite && r_wb_rd != '0 && r_wb_rd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_fwd_a = fwd_sel(r_ex_rs1);
    assign w_fwd_b = fwd_sel(r_ex_rs2);
    assign fwd_a_o = (FWD_EN != 0) ? w_fwd_a : 2'b00;
    assign fwd_b_o = (FWD_EN != 0) ? w_fwd_b : 2'b00;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_regwrite  <= 1'b0;
            r_ex_memtoreg  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_ex_memwrite  <= 1'b0;
            r_ex_branch    <= 1'b0;
            r_ex_alusrc    <= 1'b0;
            r_ex_aluop     <= '0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_rd        <= '0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_rd       <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_rd        <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_regwrite <= 1'b0;
                r_ex_memtoreg <= 1'b0;
                r_ex_memread  <= 1'b0;
                r_ex_memwrite <= 1'b0;
                r_ex_branch   <= 1'b0;
                r_ex_alusrc   <= 1'b0;
                r_ex_aluop    <= '0;
                r_ex_rs1      <= '0;
                r_ex_rs2      <= '0;
                r_ex_rd       <= '0;
            end else begin
                r_ex_regwrite <= w_regwrite;
                r_ex_memtoreg <= w_memtoreg;
                r_ex_memread  <= w_memread;
                r_ex_memwrite <= w_memwrite;
                r_ex_branch   <= w_branch;
                r_ex_alusrc   <= w_alusrc;
                r_ex_aluop    <= w_aluop;
                r_ex_rs1      <= rs1_i;
                r_ex_rs2      <= rs2_i;
                r_ex_rd       <= rd_i;
            end
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_memread  <= r_ex_memread;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_rd       <= r_ex_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_rd        <= r_mem_rd;
        end
    end

    assign ex_aluop_o     = r_ex_aluop;
    assign ex_alusrc_o    = r_ex_alusrc;
    assign ex_branch_o    = r_ex_branch;
    assign mem_memread_o  = r_mem_memread;
    assign mem_memwrite_o = r_mem_memwrite;
    assign wb_regwrite_o  = r_wb_regwrite;
    assign wb_memtoreg_o  = r_wb_memtoreg;
    assign wb_rd_o        = r_wb_rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with forwarding, one without,
// sharing stimulus; each scenario checks the instance it targets.
module tb_pipe_ctrl_unit;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_UNK = 7'b1111111;
    localparam logic [6:0] OP_NOP = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = OP_NOP;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       flush = 1'b0;

    logic       f1_stall, f1_alusrc, f1_branch, f1_mread, f1_mwrite, f1_rw, f1_m2r;
    logic [1:0] f1_aluop, f1_fa, f1_fb;
    logic [4:0] f1_wbrd;
    logic       f0_stall, f0_alusrc, f0_branch, f0_mread, f0_mwrite, f0_rw, f0_m2r;
    logic [1:0] f0_aluop, f0_fa, f0_fb;
    logic [4:0] f0_wbrd;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(2), .FWD_EN(1)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .flush_i(flush), .stall_o(f1_stall), .ex_aluop_o(f1_aluop), .ex_alusrc_o(f1_alusrc),
        .ex_branch_o(f1_branch), .mem_memread_o(f1_mread), .mem_memwrite_o(f1_mwrite),
        .wb_regwrite_o(f1_rw), .wb_memtoreg_o(f1_m2r), .wb_rd_o(f1_wbrd),
        .fwd_a_o(f1_fa), .fwd_b_o(f1_fb)
    );

    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(2), .FWD_EN(0)) u_dut_nofwd (
        .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .flush_i(flush), .stall_o(f0_stall), .ex_aluop_o(f0_aluop), .ex_alusrc_o(f0_alusrc),
        .ex_branch_o(f0_branch), .mem_memread_o(f0_mread), .mem_memwrite_o(f0_mwrite),
        .wb_regwrite_o(f0_rw), .wb_memtoreg_o(f0_m2r), .wb_rd_o(f0_wbrd),
        .fwd_a_o(f0_fa), .fwd_b_o(f0_fb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic id(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d);
        opcode = op;
        rs1    = a;
        rs2    = b;
        rd     = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        id(OP_NOP, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_stall",   32'(f1_stall), 0);
        chk("rst_aluop",   32'(f1_aluop), 0);
        chk("rst_alusrc",  32'(f1_alusrc), 0);
        chk("rst_wb_rw",   32'(f1_rw), 0);
        chk("rst_wb_rd",   32'(f1_wbrd), 0);
        chk("rst_fwd_a",   32'(f1_fa), 0);
        chk("rst_f0_stall", 32'(f0_stall), 0);

        // single add x3,x1,x2 held in ID
        do_reset();
        id(OP_R, 1, 2, 3);
        tick();
        chk("add_ex_aluop",  32'(f1_aluop), 2);
        chk("add_ex_alusrc", 32'(f1_alusrc), 0);
        tick();
        tick();
        chk("add_wb_rw",  32'(f1_rw), 1);
        chk("add_wb_m2r", 32'(f1_m2r), 0);
        chk("add_wb_rd",  32'(f1_wbrd), 3);

        // load-use: lw x5 ; add x6,x5,x1
        do_reset();
        id(OP_LD, 1, 0, 5);
        tick();
        id(OP_R, 5, 1, 6);
        #1;
        chk("lu_stall1", 32'(f1_stall), 1);
        tick();
        chk("lu_stall2",  32'(f1_stall), 0);
        chk("lu_bub_alu", 32'(f1_aluop), 0);
        chk("lu_bub_src", 32'(f1_alusrc), 0);
        tick();
        chk("lu_add_alu", 32'(f1_aluop), 2);
        chk("lu_fwd_a",   32'(f1_fa), 1);
        chk("lu_fwd_b",   32'(f1_fb), 0);
        chk("lu_wb_m2r",  32'(f1_m2r), 1);
        chk("lu_wb_rd",   32'(f1_wbrd), 5);

        // addi x2 ; sub x4,x2,x2 -> EX/MEM forward both operands
        do_reset();
        id(OP_I, 1, 0, 2);
        tick();
        id(OP_R, 2, 2, 4);
        #1;
        chk("raw_stall", 32'(f1_stall), 0);
        tick();
        chk("raw_fwd_a", 32'(f1_fa), 2);
        chk("raw_fwd_b", 32'(f1_fb), 2);

        // same with rd=x0 -> no forwarding
        do_reset();
        id(OP_I, 1, 0, 0);
        tick();
        id(OP_R, 0, 0, 4);
        tick();
        chk("x0_fwd_a", 32'(f1_fa), 0);
        chk("x0_fwd_b", 32'(f1_fb), 0);

        // lw x0 ; use x0 -> no stall
        do_reset();
        id(OP_LD, 1, 0, 0);
        tick();
        id(OP_R, 0, 0, 6);
        #1;
        chk("x0_ld_stall", 32'(f1_stall), 0);

        // EX/MEM beats MEM/WB: addi x2 ; addi x2 ; add x4,x2,x3
        do_reset();
        id(OP_I, 1, 0, 2);
        tick();
        id(OP_I, 1, 0, 2);
        tick();
        id(OP_R, 2, 3, 4);
        tick();
        chk("prio_fwd_a", 32'(f1_fa), 2);
        chk("prio_fwd_b", 32'(f1_fb), 0);

        // load-use with flush in the same cycle
        do_reset();
        id(OP_LD, 1, 0, 5);
        tick();
        id(OP_R, 5, 1, 6);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(f1_stall), 0);
        tick();
        flush = 1'b0;
        id(OP_NOP, 0, 0, 0);
        chk("fl_ex_alu", 32'(f1_aluop), 0);
        chk("fl_ex_src", 32'(f1_alusrc), 0);
        chk("fl_ex_br",  32'(f1_branch), 0);
        tick();
        chk("fl_mem_rd", 32'(f1_mread), 0);

        // decode sweep: store, branch, unknown, addi x10, then drain
        do_reset();
        id(OP_ST, 1, 2, 0);
        tick();
        chk("st_ex_src", 32'(f1_alusrc), 1);
        chk("st_ex_alu", 32'(f1_aluop), 0);
        id(OP_BR, 3, 4, 0);
        tick();
        chk("br_ex_alu", 32'(f1_aluop), 1);
        chk("br_ex_src", 32'(f1_alusrc), 0);
        chk("br_ex_br",  32'(f1_branch), 1);
        chk("st_mem_wr", 32'(f1_mwrite), 1);
        chk("st_mem_rd", 32'(f1_mread), 0);
        id(OP_UNK, 9, 9, 9);
        tick();
        chk("unk_ex_alu", 32'(f1_aluop), 0);
        chk("unk_ex_src", 32'(f1_alusrc), 0);
        chk("unk_ex_br",  32'(f1_branch), 0);
        chk("br_mem_wr",  32'(f1_mwrite), 0);
        chk("st_wb_rw",   32'(f1_rw), 0);
        id(OP_I, 1, 0, 10);
        tick();
        chk("i_ex_alu",   32'(f1_aluop), 3);
        chk("i_ex_src",   32'(f1_alusrc), 1);
        chk("unk_mem_wr", 32'(f1_mwrite), 0);
        chk("unk_mem_rd", 32'(f1_mread), 0);
        id(OP_NOP, 0, 0, 0);
        tick();
        chk("unk_wb_rw", 32'(f1_rw), 0);
        tick();
        chk("i_wb_rw", 32'(f1_rw), 1);
        chk("i_wb_rd", 32'(f1_wbrd), 10);

        // no forwarding: addi x7 ; add x8,x7,x0 -> two stall cycles
        do_reset();
        id(OP_I, 1, 0, 7);
        tick();
        id(OP_R, 7, 0, 8);
        #1;
        chk("nf_stall1", 32'(f0_stall), 1);
        chk("nf_fa1",    32'(f0_fa), 0);
        tick();
        chk("nf_stall2", 32'(f0_stall), 1);
        chk("nf_bub",    32'(f0_aluop), 0);
        chk("nf_fb2",    32'(f0_fb), 0);
        tick();
        chk("nf_stall3", 32'(f0_stall), 0);
        tick();
        chk("nf_add_alu", 32'(f0_aluop), 2);
        chk("nf_fa4",     32'(f0_fa), 0);
        chk("nf_fb4",     32'(f0_fb), 0);

        // async reset during a load-use stall
        do_reset();
        id(OP_LD, 1, 0, 5);
        tick();
        id(OP_R, 5, 1, 6);
        #1;
        chk("ar_stall_pre", 32'(f1_stall), 1);
        chk("ar_src_pre",   32'(f1_alusrc), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_stall",    32'(f1_stall), 0);
        chk("ar_src",      32'(f1_alusrc), 0);
        chk("ar_f0_stall", 32'(f0_stall), 0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle opcode decoder.
- Decodes the ID-stage instruction fields into a full RV32I control bundle: R, I-ALU, load, store and branch.
- Carries the bundle through internal ID/EX, EX/MEM and MEM/WB control registers.
- Owns load-use hazard detection (stall/bubble), flush bubbling and EX-stage operand forwarding select, so the datapath stage registers carry only data.

Parameters:
- REG_AW, 5: register-address width for rs1/rs2/rd fields and internal rd/rs tracking.
- ALUOP_W, 2: ALUOp width; upper bits above bit 1 are always driven 0.
- FWD_EN, 1: 1 = forwarding enabled, stall only on load-use; 0 = forwarding disabled, forward selects tied 00, stall on any RAW against the EX or MEM stage.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- opcode_i  in  7  ID-stage instruction [6:0].
- rs1_i  in  REG_AW  ID-stage rs1 field.
- rs2_i  in  REG_AW  ID-stage rs2 field.
- rd_i  in  REG_AW  ID-stage rd field.
- flush_i  in  1  branch taken; the current ID instruction is dead.
- stall_o  out  1  hold PC and IF/ID this cycle.
- ex_aluop_o  out  ALUOP_W  EX-stage ALUOp.
- ex_alusrc_o  out  1  EX-stage ALU operand B: 1 = immediate.
- ex_branch_o  out  1  EX-stage branch flag.
- mem_memread_o  out  1  MEM-stage load.
- mem_memwrite_o  out  1  MEM-stage store.
- wb_regwrite_o  out  1  WB-stage register write.
- wb_memtoreg_o  out  1  WB-stage writeback source: 1 = memory.
- wb_rd_o  out  REG_AW  WB-stage destination register.
- fwd_a_o  out  2  EX operand A select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB.
- fwd_b_o  out  2  EX operand B select, same encoding.

Behaviour:
- Decode (combinational, ID stage), listed as RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp:
  - 0110011 (R): 1,0,0,0,0,0,10
  - 0010011 (I-ALU): 1,0,0,0,0,1,11
  - 0000011 (load): 1,1,1,0,0,1,00
  - 0100011 (store): 0,0,0,1,0,1,00
  - 1100011 (branch): 0,0,0,0,1,0,01
  - any other opcode: every control bit 0, including ALUSrc.
- Operand use:
  - rs1 is used by all five decoded classes.
  - rs2 is used only by R, store and branch.
  - Unused rs fields never cause a hazard.
- Pipeline registers: ID/EX holds the bundle plus rs1, rs2 and rd; EX/MEM holds RegWrite, MemtoReg, MemRead, MemWrite and rd; MEM/WB holds RegWrite, MemtoReg and rd. All three advance every clock; there is no enable.
- Hazard with FWD_EN=1: asserted when ex_memread=1, ex_rd≠0 and ex_rd equals a used rs field.
- Hazard with FWD_EN=0: asserted when (ex_regwrite=1 and ex_rd≠0 and ex_rd matches a used rs) or (mem_regwrite=1 and mem_rd≠0 and mem_rd matches a used rs). The register file is write-before-read, so WB is never a hazard.
- stall_o = hazard & ~flush_i (combinational). Flush wins, because a dead instruction must not stall.
- Bubble: if hazard=1 or flush_i=1, ID/EX loads all-zero control with rs1/rs2/rd = 0; otherwise it loads the decoded bundle and fields.
- A load-use stall lasts exactly 1 cycle (FWD_EN=1). With FWD_EN=0, a RAW hazard stalls 1 or 2 cycles.
- Forwarding (combinational from ID/EX, EX/MEM and MEM/WB):
  - fwd_a_o = 10 if mem_regwrite=1, mem_rd≠0 and mem_rd == ex_rs1.
  - Else fwd_a_o = 01 if wb_regwrite=1, wb_rd≠0 and wb_rd == ex_rs1.
  - Else fwd_a_o = 00.
  - fwd_b_o uses the same rules against ex_rs2.
  - EX/MEM has priority over MEM/WB.
  - With FWD_EN=0 both selects are constant 00.
- Register x0: rd = 0 never forwards and never stalls.
- Reset (rst_i low, asynchronous): all three pipeline registers clear to 0. Consequently every output is 0, stall_o=0 and fwd_*=00. Reset asserted mid-stall drops stall_o immediately. After release, the first decoded instruction appears on the ex_* outputs on the next rising edge.
- Latency: ID decode → ex_* outputs 1 cycle; mem_* outputs 2 cycles; wb_* outputs 3 cycles.

Test Plan:
- Reset then one add (R-type, rd=3), with no further input changes → after edge 1, ex_aluop_o=10 and ex_alusrc_o=0; after edge 3, wb_regwrite_o=1, wb_memtoreg_o=0, wb_rd_o=3.
- lw x5 followed by add x6,x5,x1 (FWD_EN=1) → stall_o=1 for exactly one cycle. A bubble reaches EX with ex_aluop_o=00. When the add reaches EX, fwd_a_o=01 and fwd_b_o=00.
- addi x2 then sub x4,x2,x2 → fwd_a_o=fwd_b_o=10 in the sub's EX cycle and stall_o stays 0. Repeat with rd=x0 → selects stay 00.
- lw x5 followed by a load-use add with flush_i=1 in the same cycle → stall_o=0 and the next ex_* control is all 0.
- FWD_EN=0: addi x7 then add x8,x7,x0 → stall_o=1 for 2 consecutive cycles and fwd_*=00 throughout. Unknown opcode 1111111 → all decoded control 0, including ALUSrc.
- rst_i pulled low during a stall cycle → stall_o and all outputs drop to 0 without waiting for a clock edge.
